skeeball_score: RTL and testbench
=================================

SKEEBALL_SCORE -- requirements
Module: skeeball_score

Interface
REQ-001 Parameter NUM_BALLS, default 9: balls per game, range 1..15.
REQ-002 Parameter MAX_SCORE, default 990: saturation ceiling; multiple of 10, at most 1023.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 menuState  input  1  decoded game state: start menu.
REQ-006 playingState  input  1  decoded game state: playing.
REQ-007 finishState  input  1  decoded game state: finish.
REQ-008 scoreState  input  1  decoded game state: last-score display.
REQ-009 holeHit  input  6  raw asynchronous hole sensors; bit0..bit5 = 10, 20, 30, 40, 50, 100 points.
REQ-010 score  output  10  running score of the current game.
REQ-011 ballsLeft  output  4  balls remaining in the current game.
REQ-012 lastScore  output  10  score of the most recently finished game.
REQ-013 highScore  output  10  best finished score since reset.
REQ-014 newHigh  output  1  set when the last finished game set a new high score.
REQ-015 gameOver  output  1  one-cycle pulse driving the state machine trigger.

Function
REQ-016 Each holeHit bit SHALL pass through a 2-flop synchronizer, then a rising-edge detector; hit-detect latency is 3 clk from the input rising edge.
REQ-017 A hit SHALL be accepted only when playingState=1 and ballsLeft>0; otherwise it is discarded without side effects.
REQ-018 Simultaneous edges on several bits in one cycle SHALL count as one ball, credited with the highest-value bit.
REQ-019 On an accepted hit, in the same cycle:
  - score <= min(score+value, MAX_SCORE);
  - ballsLeft <= ballsLeft-1.
  Both outputs update on the clock edge after detection.
REQ-020 The arithmetic SHALL use 11 bits internally so that saturation at MAX_SCORE never wraps.
REQ-021 When an accepted hit takes ballsLeft from 1 to 0, gameOver SHALL pulse high for exactly one cycle, on the cycle after ballsLeft becomes 0.
REQ-022 gameOver SHALL never assert outside playingState and SHALL never assert twice in one game.
REQ-023 On the rising edge of menuState (0 in previous cycle, 1 now), the block SHALL set score=0, ballsLeft=NUM_BALLS and newHigh=0.
REQ-024 On the rising edge of finishState, the block SHALL set lastScore<=score.
  - If score>highScore: highScore<=score and newHigh<=1.
  - Otherwise newHigh<=0; a tie is not a new high.
REQ-025 scoreState SHALL hold all outputs static; it is used for display only.
REQ-026 If playingState falls with ballsLeft>0 (external trigger), score and ballsLeft SHALL freeze and no gameOver is issued.
REQ-027 The edge detectors for menuState and finishState SHALL each use a registered copy of the previous value.

Reset
REQ-028 Reset values:
  - score=0, lastScore=0, highScore=0;
  - newHigh=0, gameOver=0;
  - ballsLeft=NUM_BALLS;
  - synchronizer and edge-detect flops=0.
REQ-029 Reset asserted mid-game SHALL take effect immediately (asynchronously), discard any in-flight hit, and clear highScore.
REQ-030 After reset deassertion, the first hit SHALL be accepted no earlier than 3 clk after a holeHit rising edge.

Structure
REQ-031 Package skeeball_pkg SHALL hold:
  - hole point-value constants;
  - the score width (10);
  - the ballsLeft width (4).
REQ-032 Sub-module skeeball_sync_edge (2-flop sync plus rising-edge pulse, 1 bit) SHALL be instantiated 6 times.
REQ-033 The hit priority-select and score adder SHALL remain in skeeball_score.

Verification
REQ-034 Reset, then menu->playing; 9 hits of 10 points spaced 10 clk apart -> score=90, ballsLeft=0, one gameOver pulse 1 clk after the 9th update.
REQ-035 bits 1 and 5 rise in the same cycle while playing -> score+=100, ballsLeft decrements by 1 only.
REQ-036 score=950, hit of 100 -> score=990 (saturated); a further 50-point hit -> score stays 990.
REQ-037 Finish with score=120 and highScore=80 -> lastScore=120, highScore=120, newHigh=1. Next game finishes with 120 -> newHigh=0, highScore=120.
REQ-038 Hits while in menuState, or after ballsLeft=0 -> score, ballsLeft and gameOver unchanged.
REQ-039 Assert rst for 1 clk at ballsLeft=4, score=200 -> all outputs return to reset values immediately and highScore=0.

Source files
------------

// File: rtl/skeeball_pkg.sv
// Shared constants for the skee-ball scoring block: widths and hole values.
package skeeball_pkg;

  localparam int SCORE_W   = 10;           // score, lastScore, highScore
  localparam int BALLS_W   = 4;            // ballsLeft
  localparam int SUM_W     = SCORE_W + 1;  // headroom so saturation never wraps
  localparam int NUM_HOLES = 6;

  // Point value of each hole sensor, bit0..bit5.
  localparam logic [SCORE_W-1:0] HOLE0_PTS = 10'd10;
  localparam logic [SCORE_W-1:0] HOLE1_PTS = 10'd20;
  localparam logic [SCORE_W-1:0] HOLE2_PTS = 10'd30;
  localparam logic [SCORE_W-1:0] HOLE3_PTS = 10'd40;
  localparam logic [SCORE_W-1:0] HOLE4_PTS = 10'd50;
  localparam logic [SCORE_W-1:0] HOLE5_PTS = 10'd100;

endpackage

// File: rtl/skeeball_sync_edge.sv
// One hole sensor: two-flop synchronizer followed by a rising-edge pulse.
// The pulse is high for one cycle, two clocks after the sensor rises, so
// the score register picks it up on the third clock.
module skeeball_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronize the raw sensor and keep one delayed copy for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, giving a true shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/skeeball_score.sv
// Skee-ball score keeper: synchronizes hole sensors, credits one ball per
// detected hit with the highest-value hole, saturates the score, counts balls
// down, pulses gameOver once at the end of a game and tracks last/high score.
module skeeball_score
  import skeeball_pkg::*;
#(
  parameter int NUM_BALLS = 9,
  parameter int MAX_SCORE = 990
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               menuState,
  input  logic               playingState,
  input  logic               finishState,
  input  logic               scoreState,
  input  logic [5:0]         holeHit,
  output logic [SCORE_W-1:0] score,
  output logic [BALLS_W-1:0] ballsLeft,
  output logic [SCORE_W-1:0] lastScore,
  output logic [SCORE_W-1:0] highScore,
  output logic               newHigh,
  output logic               gameOver
);

  localparam logic [BALLS_W-1:0] BALLS_INIT  = BALLS_W'(NUM_BALLS);
  localparam logic [BALLS_W-1:0] ONE_BALL    = BALLS_W'(1);
  localparam logic [SUM_W-1:0]   MAX_SUM     = SUM_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] MAX_SCORE_V = SCORE_W'(MAX_SCORE);

  logic [NUM_HOLES-1:0] hole_rise;
  logic                 menu_q;
  logic                 finish_q;
  logic                 menu_rise;
  logic                 finish_rise;
  logic [SCORE_W-1:0]   hit_val;
  logic [SUM_W-1:0]     sum;
  logic [SCORE_W-1:0]   next_score;
  logic                 accept;
  logic                 go_pending;

  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_sync
    skeeball_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (holeHit[i]),
      .rise (hole_rise[i])
    );
  end

  // Previous-cycle copies of the menu and finish states for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      menu_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      menu_q   <= menuState;
      finish_q <= finishState;
    end
  end

  assign menu_rise   = menuState & ~menu_q;
  assign finish_rise = finishState & ~finish_q;

  // Several holes in one cycle are one ball: credit the highest-value hole.
  // NOTE: the default before the if-chain keeps this purely combinational;
  // without it a cycle with no hit would have to remember hit_val (a latch).
  always_comb begin
    hit_val = '0;
    if      (hole_rise[5]) hit_val = HOLE5_PTS;
    else if (hole_rise[4]) hit_val = HOLE4_PTS;
    else if (hole_rise[3]) hit_val = HOLE3_PTS;
    else if (hole_rise[2]) hit_val = HOLE2_PTS;
    else if (hole_rise[1]) hit_val = HOLE1_PTS;
    else if (hole_rise[0]) hit_val = HOLE0_PTS;
  end

  // Score display freezes everything even if state decode ever overlaps.
  assign accept     = playingState & ~scoreState & (ballsLeft != '0) & (|hole_rise);
  assign sum        = {1'b0, score} + {1'b0, hit_val};
  assign next_score = (sum > MAX_SUM) ? MAX_SCORE_V : sum[SCORE_W-1:0];

  // Game bookkeeping: new game, ball scoring, end-of-game pulse, results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score      <= '0;
      ballsLeft  <= BALLS_INIT;
      lastScore  <= '0;
      highScore  <= '0;
      newHigh    <= 1'b0;
      gameOver   <= 1'b0;
      go_pending <= 1'b0;
    end else begin
      // The last ball sets go_pending; gameOver follows one cycle later and
      // only while still playing, so it can fire at most once per game.
      go_pending <= 1'b0;
      gameOver   <= go_pending & playingState;
      if (menu_rise) begin
        score     <= '0;
        ballsLeft <= BALLS_INIT;
        newHigh   <= 1'b0;
      end else if (accept) begin
        score      <= next_score;
        ballsLeft  <= ballsLeft - ONE_BALL;
        go_pending <= (ballsLeft == ONE_BALL);
      end
      if (finish_rise) begin
        lastScore <= score;
        if (score > highScore) begin
          highScore <= score;
          newHigh   <= 1'b1;
        end else begin
          newHigh   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_skeeball_score.sv
// Bench for skeeball_score: reset check, a table of scripted game steps,
// hand-written multi-cycle sequences, and randomized games against a model.
module tb_skeeball_score;

  logic       clk = 1'b0;
  logic       rst;
  logic       menuState, playingState, finishState, scoreState;
  logic [5:0] holeHit;

  logic [9:0] score, lastScore, highScore;
  logic [3:0] ballsLeft;
  logic       newHigh, gameOver;

  logic [9:0] score15, last15, high15;
  logic [3:0] balls15;
  logic       new15, go15;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  skeeball_score dut (
    .clk          (clk),
    .rst          (rst),
    .menuState    (menuState),
    .playingState (playingState),
    .finishState  (finishState),
    .scoreState   (scoreState),
    .holeHit      (holeHit),
    .score        (score),
    .ballsLeft    (ballsLeft),
    .lastScore    (lastScore),
    .highScore    (highScore),
    .newHigh      (newHigh),
    .gameOver     (gameOver)
  );

  // Second instance with more balls, so the saturation point is reachable.
  skeeball_score #(.NUM_BALLS(15), .MAX_SCORE(990)) dut15 (
    .clk          (clk),
    .rst          (rst),
    .menuState    (menuState),
    .playingState (playingState),
    .finishState  (finishState),
    .scoreState   (scoreState),
    .holeHit      (holeHit),
    .score        (score15),
    .ballsLeft    (balls15),
    .lastScore    (last15),
    .highScore    (high15),
    .newHigh      (new15),
    .gameOver     (go15)
  );

  // Watch gameOver pulses and the cycle ballsLeft reaches zero.
  int         cyc = 0;
  int         zero_cyc = -1;
  int         go_cyc = -1;
  int         go_cnt = 0;
  logic [3:0] prev_balls = 4'd9;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_balls != 4'd0 && ballsLeft == 4'd0) zero_cyc = cyc;
    if (gameOver === 1'b1) begin
      go_cnt = go_cnt + 1;
      go_cyc = cyc;
    end
    prev_balls = ballsLeft;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // 0 menu, 1 playing, 2 finish, 3 score display
  task automatic set_state(input int s);
    @(negedge clk);
    menuState    = (s == 0);
    playingState = (s == 1);
    finishState  = (s == 2);
    scoreState   = (s == 3);
    repeat (2) @(negedge clk);
  endtask

  // One ball: sensors held 4 clocks, then quiet; ends on a negedge.
  task automatic hit(input logic [5:0] m);
    @(negedge clk);
    holeHit = m;
    repeat (4) @(negedge clk);
    holeHit = 6'h00;
    repeat (5) @(negedge clk);
  endtask

  // ---- Reference model ----
  int m_score, m_balls, m_last, m_high, m_new;

  function automatic int pts(input logic [5:0] m);
    int v[6];
    v = '{10, 20, 30, 40, 50, 100};
    for (int b = 5; b >= 0; b--)
      if (m[b]) return v[b];
    return 0;
  endfunction

  // ---- Scripted table ----
  typedef enum {OP_MENU, OP_PLAY, OP_HIT, OP_FINISH, OP_SHOW} op_e;
  typedef struct {
    op_e        op;
    logic [5:0] holes;
    int         sc;
    int         balls;
    int         last;
    int         high;
    int         nh;
  } vec_t;
  vec_t vecs[18];

  initial begin
    int go_base;
    rst = 1'b1;
    menuState = 1'b0; playingState = 1'b0; finishState = 1'b0; scoreState = 1'b0;
    holeHit = 6'h00;

    vecs[0]  = '{OP_MENU,   6'h00,   0, 9,   0,   0, 0};
    vecs[1]  = '{OP_HIT,    6'h01,   0, 9,   0,   0, 0};  // hit in menu ignored
    vecs[2]  = '{OP_PLAY,   6'h00,   0, 9,   0,   0, 0};
    vecs[3]  = '{OP_HIT,    6'h08,  40, 8,   0,   0, 0};
    vecs[4]  = '{OP_HIT,    6'h08,  80, 7,   0,   0, 0};
    vecs[5]  = '{OP_FINISH, 6'h00,  80, 7,  80,  80, 1};
    vecs[6]  = '{OP_SHOW,   6'h00,  80, 7,  80,  80, 1};
    vecs[7]  = '{OP_HIT,    6'h01,  80, 7,  80,  80, 1};  // hit in display ignored
    vecs[8]  = '{OP_MENU,   6'h00,   0, 9,  80,  80, 0};
    vecs[9]  = '{OP_PLAY,   6'h00,   0, 9,  80,  80, 0};
    vecs[10] = '{OP_HIT,    6'h22, 100, 8,  80,  80, 0};  // bits 1 and 5 together
    vecs[11] = '{OP_HIT,    6'h02, 120, 7,  80,  80, 0};
    vecs[12] = '{OP_FINISH, 6'h00, 120, 7, 120, 120, 1};
    vecs[13] = '{OP_MENU,   6'h00,   0, 9, 120, 120, 0};
    vecs[14] = '{OP_PLAY,   6'h00,   0, 9, 120, 120, 0};
    vecs[15] = '{OP_HIT,    6'h20, 100, 8, 120, 120, 0};
    vecs[16] = '{OP_HIT,    6'h03, 120, 7, 120, 120, 0};
    vecs[17] = '{OP_FINISH, 6'h00, 120, 7, 120, 120, 0};  // tie is not a new high

    // Reset values
    repeat (3) @(negedge clk);
    check("rst score",     score,     0);
    check("rst ballsLeft", ballsLeft, 9);
    check("rst lastScore", lastScore, 0);
    check("rst highScore", highScore, 0);
    check("rst newHigh",   newHigh,   0);
    check("rst gameOver",  gameOver,  0);
    rst = 1'b0;
    @(negedge clk);

    go_base = go_cnt;
    for (int i = 0; i < 18; i++) begin
      case (vecs[i].op)
        OP_MENU:   set_state(0);
        OP_PLAY:   set_state(1);
        OP_FINISH: set_state(2);
        OP_SHOW:   set_state(3);
        default:   hit(vecs[i].holes);
      endcase
      check($sformatf("vec%0d score", i),     score,     vecs[i].sc);
      check($sformatf("vec%0d ballsLeft", i), ballsLeft, vecs[i].balls);
      check($sformatf("vec%0d lastScore", i), lastScore, vecs[i].last);
      check($sformatf("vec%0d highScore", i), highScore, vecs[i].high);
      check($sformatf("vec%0d newHigh", i),   newHigh,   vecs[i].nh);
    end
    check("table gameOver count", go_cnt - go_base, 0);

    // Nine 10-point balls, with exact hit latency on the first one.
    set_state(0);
    set_state(1);
    go_base = go_cnt;
    @(negedge clk);
    holeHit = 6'h01;
    repeat (2) @(negedge clk);
    check("latency 2 clk score", score, 0);
    @(negedge clk);
    check("latency 3 clk score", score, 10);
    repeat (2) @(negedge clk);
    holeHit = 6'h00;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) hit(6'h01);
    check("nine balls score",     score,     90);
    check("nine balls ballsLeft", ballsLeft, 0);
    check("gameOver pulses",      go_cnt - go_base, 1);
    check("gameOver delay",       go_cyc - zero_cyc, 1);
    hit(6'h20);
    check("after last score",     score,     90);
    check("after last ballsLeft", ballsLeft, 0);
    check("after last gameOver",  go_cnt - go_base, 1);
    set_state(2);
    check("game90 lastScore", lastScore, 90);
    check("game90 highScore", highScore, 120);
    check("game90 newHigh",   newHigh,   0);
    check("finish no gameOver", go_cnt - go_base, 1);

    // Saturation on the 15-ball instance; default instance out of balls.
    set_state(0);
    set_state(1);
    for (int i = 0; i < 9; i++) hit(6'h20);
    check("sat dut score",    score,   900);
    check("sat dut15 score",  score15, 900);
    check("sat dut15 balls",  balls15, 6);
    hit(6'h10);
    check("sat dut15 950",    score15, 950);
    check("empty dut score",  score,   900);
    check("empty dut balls",  ballsLeft, 0);
    hit(6'h20);
    check("sat dut15 990",    score15, 990);
    check("sat dut15 balls4", balls15, 4);
    hit(6'h10);
    check("sat dut15 hold",   score15, 990);
    check("sat dut15 balls3", balls15, 3);
    set_state(2);
    check("sat dut last",     lastScore, 900);
    check("sat dut high",     highScore, 900);
    check("sat dut newHigh",  newHigh,   1);
    check("sat dut15 high",   high15,    990);

    // Reset mid-game with a hit in flight.
    set_state(0);
    set_state(1);
    hit(6'h20); hit(6'h10); hit(6'h02); hit(6'h02); hit(6'h01);
    check("pre-rst score", score,     200);
    check("pre-rst balls", ballsLeft, 4);
    @(negedge clk);
    holeHit = 6'h20;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst score",     score,     0);
    check("async rst ballsLeft", ballsLeft, 9);
    check("async rst lastScore", lastScore, 0);
    check("async rst highScore", highScore, 0);
    check("async rst newHigh",   newHigh,   0);
    check("async rst gameOver",  gameOver,  0);
    holeHit = 6'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("in-flight hit dropped score", score,     0);
    check("in-flight hit dropped balls", ballsLeft, 9);

    // Randomized games against the model.
    m_score = 0; m_balls = 9; m_last = 0; m_high = 0; m_new = 0;
    for (int g = 0; g < 20; g++) begin
      int n;
      set_state(0);
      m_score = 0; m_balls = 9; m_new = 0;
      go_base = go_cnt;
      if ($urandom_range(0, 3) == 0) begin
        hit(6'($urandom_range(1, 63)));
        check($sformatf("g%0d menu hit score", g), score,     m_score);
        check($sformatf("g%0d menu hit balls", g), ballsLeft, m_balls);
      end
      set_state(1);
      n = $urandom_range(2, 11);
      for (int k = 0; k < n; k++) begin
        logic [5:0] m;
        m = 6'($urandom_range(1, 63));
        hit(m);
        if (m_balls > 0) begin
          m_score = (m_score + pts(m) > 990) ? 990 : m_score + pts(m);
          m_balls = m_balls - 1;
        end
        check($sformatf("g%0d hit%0d score", g, k), score,     m_score);
        check($sformatf("g%0d hit%0d balls", g, k), ballsLeft, m_balls);
      end
      set_state(2);
      m_last = m_score;
      if (m_score > m_high) begin
        m_high = m_score;
        m_new  = 1;
      end else begin
        m_new  = 0;
      end
      check($sformatf("g%0d lastScore", g), lastScore, m_last);
      check($sformatf("g%0d highScore", g), highScore, m_high);
      check($sformatf("g%0d newHigh", g),   newHigh,   m_new);
      check($sformatf("g%0d gameOver", g),  go_cnt - go_base, (m_balls == 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
